// File: rtl/cache_mesi_home.sv
// Home-side MESI directory: per-line state/owner/sharers, recalls conflicting copies with FORCE_EVICT snoops.
// Latency: response 1 cycle after acceptance without recall; each recall adds snoop handshake plus ack.
// Backpressure: one transaction in flight, req_ready low while busy; resp/snp held stable until ready.
// Optional feature macro: CACHE_MESI_HOME_UPGRADE_PROMOTE_EN (UPGRADE from a non-sharer becomes MODIFIED).
module cache_mesi_home #(
  parameter int PORTS       = 2,
  parameter int INDEX_WIDTH = 4,
  localparam int ID_WIDTH   = $clog2(PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ID_WIDTH-1:0]    req_id,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [2:0]             req_op,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_WIDTH-1:0]    resp_id,
  output logic [INDEX_WIDTH-1:0] resp_index,
  output logic [2:0]             resp_op,
  output logic                   snp_valid,
  input  logic                   snp_ready,
  output logic [ID_WIDTH-1:0]    snp_id,
  output logic [INDEX_WIDTH-1:0] snp_index,
  output logic [2:0]             snp_op,
  input  logic                   ack_valid,
  output logic                   ack_ready,
  input  logic [ID_WIDTH-1:0]    ack_id,
  input  logic [2:0]             ack_op,
  output logic                   wb_pulse,
  output logic                   ack_error
);
  // Shared encoding of cache_mesi_request_t / cache_mesi_response_t
  localparam logic [2:0] OP_REJECT            = 3'd0;
  localparam logic [2:0] OP_SHARED            = 3'd1;
  localparam logic [2:0] OP_MODIFIED          = 3'd2;
  localparam logic [2:0] OP_UPGRADE           = 3'd3;
  localparam logic [2:0] OP_NORMAL_EVICT      = 3'd4;
  localparam logic [2:0] OP_NORMAL_EVICT_DATA = 3'd5;
  localparam logic [2:0] OP_FORCE_EVICT       = 3'd6;
  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {L_INVALID, L_SHARED, L_MODIFIED} line_state_e;
  typedef enum logic [1:0] {S_IDLE, S_RECALL_ISSUE, S_RECALL_WAIT, S_RESPOND} fsm_e;

  line_state_e         dir_state_q   [LINES];
  logic [ID_WIDTH-1:0] dir_owner_q   [LINES];
  logic [PORTS-1:0]    dir_sharers_q [LINES];

  fsm_e                   state_q, state_d;
  logic [ID_WIDTH-1:0]    id_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [2:0]             grant_q;
  logic [PORTS-1:0]       pending_q;
  logic                   fin_we_q;
  line_state_e            fin_state_q;
  logic [ID_WIDTH-1:0]    fin_owner_q;
  logic [PORTS-1:0]       fin_sharers_q;
  logic                   wb_q, ack_err_q;

  // Request-time directory lookup results
  line_state_e         cur_state;
  logic [ID_WIDTH-1:0] cur_owner;
  logic [PORTS-1:0]    cur_sharers, r_bit;
  logic [2:0]          grant_d;
  logic [PORTS-1:0]    pend_d, fsh_d;
  logic                we_d;
  line_state_e         fst_d;
  logic [ID_WIDTH-1:0] fown_d;
  // Recall target
  logic [ID_WIDTH-1:0] snp_tgt;
  logic [PORTS-1:0]    tgt_bit, pend_left;
  logic                ack_hit;

  // Grant decision and final directory entry for the incoming request
  always_comb begin
    cur_state   = dir_state_q[req_index];
    cur_owner   = dir_owner_q[req_index];
    cur_sharers = dir_sharers_q[req_index];
    r_bit       = PORTS'(1) << req_id;
    grant_d     = OP_REJECT;
    pend_d      = '0;
    we_d        = 1'b0;
    fst_d       = cur_state;
    fown_d      = cur_owner;
    fsh_d       = cur_sharers;
    case (req_op)
      OP_SHARED: begin
        if (!(cur_state == L_MODIFIED && cur_owner == req_id)) begin
          if (cur_state == L_MODIFIED) pend_d = PORTS'(1) << cur_owner;
          grant_d = OP_SHARED;
          we_d    = 1'b1;
          fst_d   = L_SHARED;
          fsh_d   = (cur_sharers & ~pend_d) | r_bit;
        end
      end
      OP_MODIFIED: begin
        pend_d  = cur_sharers & ~r_bit;
        grant_d = OP_MODIFIED;
        we_d    = 1'b1;
        fst_d   = L_MODIFIED;
        fown_d  = req_id;
        fsh_d   = r_bit;
      end
      OP_UPGRADE: begin
        if (cur_state == L_SHARED && (cur_sharers & r_bit) != '0) begin
          pend_d  = cur_sharers & ~r_bit;
          grant_d = OP_UPGRADE;
          we_d    = 1'b1;
          fst_d   = L_MODIFIED;
          fown_d  = req_id;
          fsh_d   = r_bit;
        end
`ifdef CACHE_MESI_HOME_UPGRADE_PROMOTE_EN
        else begin
          // Stale upgrader lost its copy: hand it a full MODIFIED grant so it refetches
          pend_d  = cur_sharers & ~r_bit;
          grant_d = OP_MODIFIED;
          we_d    = 1'b1;
          fst_d   = L_MODIFIED;
          fown_d  = req_id;
          fsh_d   = r_bit;
        end
`endif
      end
      OP_NORMAL_EVICT: begin
        if (cur_state == L_SHARED && (cur_sharers & r_bit) != '0) begin
          grant_d = OP_NORMAL_EVICT;
          we_d    = 1'b1;
          fsh_d   = cur_sharers & ~r_bit;
          fst_d   = ((cur_sharers & ~r_bit) == '0) ? L_INVALID : L_SHARED;
        end
      end
      OP_NORMAL_EVICT_DATA: begin
        if (cur_state == L_MODIFIED && cur_owner == req_id) begin
          grant_d = OP_NORMAL_EVICT_DATA;
          we_d    = 1'b1;
          fst_d   = L_INVALID;
          fsh_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Lowest set bit of the pending recall set is the next snoop target
  always_comb begin
    snp_tgt = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (pending_q[i]) snp_tgt = ID_WIDTH'(i);
    end
    tgt_bit   = PORTS'(1) << snp_tgt;
    pend_left = pending_q & ~tgt_bit;
    ack_hit   = ack_valid && (ack_id == snp_tgt);
  end

  // FSM next state and handshake outputs; everything idles low while rst is high
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    snp_valid  = 1'b0;
    ack_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_d = (pend_d != '0) ? S_RECALL_ISSUE : S_RESPOND;
      end
      S_RECALL_ISSUE: begin
        snp_valid = !rst;
        if (snp_ready) state_d = S_RECALL_WAIT;
      end
      S_RECALL_WAIT: begin
        ack_ready = !rst;
        if (ack_hit) state_d = (pend_left != '0) ? S_RECALL_ISSUE : S_RESPOND;
      end
      S_RESPOND: begin
        resp_valid = !rst;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_id    = id_q;
  assign resp_index = index_q;
  assign resp_op    = grant_q;
  assign snp_id     = snp_tgt;
  assign snp_index  = index_q;
  assign snp_op     = snp_valid ? OP_FORCE_EVICT : OP_REJECT;
  assign wb_pulse   = wb_q;
  assign ack_error  = ack_err_q;

  // State register, transaction capture, recall bookkeeping and directory writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      id_q          <= '0;
      index_q       <= '0;
      grant_q       <= OP_REJECT;
      pending_q     <= '0;
      fin_we_q      <= 1'b0;
      fin_state_q   <= L_INVALID;
      fin_owner_q   <= '0;
      fin_sharers_q <= '0;
      wb_q          <= 1'b0;
      ack_err_q     <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        dir_state_q[i]   <= L_INVALID;
        dir_owner_q[i]   <= '0;
        dir_sharers_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wb_q      <= 1'b0;
      ack_err_q <= 1'b0;
      if (state_q == S_IDLE && req_valid) begin
        id_q          <= req_id;
        index_q       <= req_index;
        grant_q       <= grant_d;
        pending_q     <= pend_d;
        fin_we_q      <= we_d;
        fin_state_q   <= fst_d;
        fin_owner_q   <= fown_d;
        fin_sharers_q <= fsh_d;
        wb_q          <= (grant_d == OP_NORMAL_EVICT_DATA);
        if (pend_d == '0 && we_d) begin
          dir_state_q[req_index]   <= fst_d;
          dir_owner_q[req_index]   <= fown_d;
          dir_sharers_q[req_index] <= fsh_d;
        end
      end
      if (state_q == S_RECALL_WAIT && ack_valid) begin
        if (ack_hit) begin
          pending_q <= pend_left;
          wb_q      <= (ack_op == OP_NORMAL_EVICT_DATA);
          if (pend_left == '0 && fin_we_q) begin
            dir_state_q[index_q]   <= fin_state_q;
            dir_owner_q[index_q]   <= fin_owner_q;
            dir_sharers_q[index_q] <= fin_sharers_q;
          end else begin
            dir_sharers_q[index_q] <= dir_sharers_q[index_q] & ~tgt_bit;
          end
        end else begin
          ack_err_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cache_mesi_home.sv
// Directed bench for cache_mesi_home: scoreboard queues for responses and snoops.
// Directory contents are checked through follow-up requests whose outcome depends on them.
// Runs with PORTS=2, INDEX_WIDTH=4.
module tb_cache_mesi_home;
  localparam int ID_W = 1;
  localparam int IX_W = 4;
  localparam logic [2:0] REJ = 3'd0, SHR = 3'd1, MOD = 3'd2, UPG = 3'd3,
                         NE = 3'd4, NED = 3'd5, FEV = 3'd6;

  typedef struct packed {logic [ID_W-1:0] id; logic [IX_W-1:0] idx; logic [2:0] op;} resp_t;
  typedef struct packed {logic [ID_W-1:0] id; logic [IX_W-1:0] idx;} snp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [ID_W-1:0] req_id = '0;
  logic [IX_W-1:0] req_index = '0;
  logic [2:0] req_op = '0;
  logic resp_valid, resp_ready = 1'b0;
  logic [ID_W-1:0] resp_id;
  logic [IX_W-1:0] resp_index;
  logic [2:0] resp_op;
  logic snp_valid, snp_ready = 1'b0;
  logic [ID_W-1:0] snp_id;
  logic [IX_W-1:0] snp_index;
  logic [2:0] snp_op;
  logic ack_valid = 1'b0, ack_ready;
  logic [ID_W-1:0] ack_id = '0;
  logic [2:0] ack_op = '0;
  logic wb_pulse, ack_error;

  int n_err = 0;
  int n_checks = 0;
  resp_t exp_q[$];
  snp_t  snp_q[$];

  always #5 clk = ~clk;

  cache_mesi_home #(.PORTS(2), .INDEX_WIDTH(IX_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_index(req_index), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_index(resp_index), .resp_op(resp_op),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_id(snp_id), .snp_index(snp_index), .snp_op(snp_op),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_id(ack_id), .ack_op(ack_op),
    .wb_pulse(wb_pulse), .ack_error(ack_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Starts and ends on a falling edge; returns on the falling edge after acceptance
  task automatic send_req(input logic [ID_W-1:0] id, input logic [IX_W-1:0] idx,
                          input logic [2:0] op, input logic [2:0] exp_op);
    int n;
    resp_t e;
    e.id = id; e.idx = idx; e.op = exp_op;
    exp_q.push_back(e);
    req_id = id; req_index = idx; req_op = op; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", 32'(n < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits up to max_wait cycles for a response, compares it, holds one cycle, then drains
  task automatic expect_resp(input string tag, input int max_wait);
    int n;
    resp_t e;
    n = 0;
    while (resp_valid !== 1'b1 && n < max_wait) begin @(negedge clk); n++; end
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_resp_q"}, 32'(exp_q.size() != 0), 32'd1);
    e = '0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_resp_id"}, 32'(resp_id), 32'(e.id));
    chk({tag, "_resp_index"}, 32'(resp_index), 32'(e.idx));
    chk({tag, "_resp_op"}, 32'(resp_op), 32'(e.op));
    @(negedge clk);
    chk({tag, "_resp_hold"}, 32'({resp_valid, resp_id, resp_index, resp_op}), 32'({1'b1, e.id, e.idx, e.op}));
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
  endtask

  // Waits for a snoop, compares with scoreboard, optional stall, then completes the handshake
  task automatic snoop_hs(input string tag, input int stall);
    int n;
    snp_t e;
    n = 0;
    while (snp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_snp_valid"}, 32'(snp_valid), 32'd1);
    e = '0;
    if (snp_q.size() != 0) e = snp_q.pop_front();
    chk({tag, "_snp"}, 32'({snp_id, snp_index, snp_op}), 32'({e.id, e.idx, FEV}));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_snp_hold"}, 32'({snp_valid, snp_id, snp_index}), 32'({1'b1, e.id, e.idx}));
    end
    snp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    snp_ready = 1'b0;
    chk({tag, "_ack_ready"}, 32'({ack_ready, snp_valid}), 32'({1'b1, 1'b0}));
  endtask

  task automatic send_ack(input string tag, input logic [ID_W-1:0] id, input logic [2:0] op,
                          input logic exp_wb, input logic exp_err);
    ack_id = id; ack_op = op; ack_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack_valid = 1'b0;
    chk({tag, "_wb_pulse"}, 32'(wb_pulse), 32'(exp_wb));
    chk({tag, "_ack_error"}, 32'(ack_error), 32'(exp_err));
  endtask

  function automatic snp_t mk_snp(input logic [ID_W-1:0] id, input logic [IX_W-1:0] idx);
    snp_t s;
    s.id = id; s.idx = idx;
    return s;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({req_ready, resp_valid, snp_valid, ack_ready, wb_pulse, ack_error}), 32'd0);
    chk("rst_ops", 32'({resp_op, snp_op}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // SHARED id0 idx3: response exactly one cycle after acceptance
    send_req(1'b0, 4'd3, SHR, SHR);
    expect_resp("t1_shared", 0);
    // Entry 3 sharers=01: MODIFIED from id1 must recall exactly id0
    snp_q.push_back(mk_snp(1'b0, 4'd3));
    send_req(1'b1, 4'd3, MOD, MOD);
    snoop_hs("t1_probe", 0);
    send_ack("t1_probe", 1'b0, NE, 1'b0, 1'b0);
    expect_resp("t1_probe", 0);
    // Non-coherent request opcode
    send_req(1'b0, 4'd3, FEV, REJ);
    expect_resp("t1_fev", 0);

    // Two sharers on idx5, then MODIFIED from id1 recalls id0 only
    send_req(1'b0, 4'd5, SHR, SHR);
    expect_resp("t2_sh0", 0);
    send_req(1'b1, 4'd5, SHR, SHR);
    expect_resp("t2_sh1", 0);
    snp_q.push_back(mk_snp(1'b0, 4'd5));
    send_req(1'b1, 4'd5, MOD, MOD);
    snoop_hs("t2_mod", 0);
    send_ack("t2_mod", 1'b0, NE, 1'b0, 1'b0);
    chk("t2_single_snoop", 32'({resp_valid, snp_valid}), 32'({1'b1, 1'b0}));
    expect_resp("t2_mod", 0);
    // Owner is id1: its dirty eviction is granted with a write-back pulse
    send_req(1'b1, 4'd5, NED, NED);
    chk("t2_ned_wb", 32'(wb_pulse), 32'd1);
    @(negedge clk);
    chk("t2_ned_wb_end", 32'(wb_pulse), 32'd0);
    expect_resp("t2_ned", 0);
    // Line now INVALID: clean eviction is rejected
    send_req(1'b0, 4'd5, NE, REJ);
    expect_resp("t2_ne_rej", 0);

    // id0 MODIFIED on idx2, SHARED from id1 recalls dirty data
    send_req(1'b0, 4'd2, MOD, MOD);
    expect_resp("t3_mod", 0);
    snp_q.push_back(mk_snp(1'b0, 4'd2));
    send_req(1'b1, 4'd2, SHR, SHR);
    snoop_hs("t3_sh", 2);
    send_ack("t3_sh", 1'b0, NED, 1'b1, 1'b0);
    chk("t3_resp_after_ack", 32'(resp_valid), 32'd1);
    @(negedge clk);
    chk("t3_wb_end", 32'(wb_pulse), 32'd0);
    expect_resp("t3_sh", 0);
    // sharers=10: id1 upgrades without any snoop
    send_req(1'b1, 4'd2, UPG, UPG);
    chk("t3_upg_no_snoop", 32'({resp_valid, snp_valid}), 32'({1'b1, 1'b0}));
    expect_resp("t3_upg", 0);
    // Now MODIFIED by id1: SHARED from id0 recalls id1
    snp_q.push_back(mk_snp(1'b1, 4'd2));
    send_req(1'b0, 4'd2, SHR, SHR);
    snoop_hs("t3_sh0", 0);
    send_ack("t3_sh0", 1'b1, NE, 1'b0, 1'b0);
    expect_resp("t3_sh0", 0);

    // UPGRADE from a non-sharer on an INVALID line
`ifdef CACHE_MESI_HOME_UPGRADE_PROMOTE_EN
    send_req(1'b1, 4'd7, UPG, MOD);
    expect_resp("t4_upg", 0);
    send_req(1'b1, 4'd7, SHR, REJ);
    expect_resp("t4_probe", 0);
`else
    send_req(1'b1, 4'd7, UPG, REJ);
    expect_resp("t4_upg", 0);
    send_req(1'b1, 4'd7, SHR, SHR);
    expect_resp("t4_probe", 0);
`endif

    // Mismatched ack is dropped with ack_error, correct ack completes
    send_req(1'b0, 4'd9, SHR, SHR);
    expect_resp("t5_sh", 0);
    snp_q.push_back(mk_snp(1'b0, 4'd9));
    send_req(1'b1, 4'd9, MOD, MOD);
    snoop_hs("t5_mod", 0);
    send_ack("t5_bad", 1'b1, NE, 1'b0, 1'b1);
    chk("t5_stay_wait", 32'({ack_ready, resp_valid, snp_valid}), 32'({1'b1, 1'b0, 1'b0}));
    send_ack("t5_good", 1'b0, NE, 1'b0, 1'b0);
    expect_resp("t5_mod", 0);

    // Reset while a snoop is outstanding
    send_req(1'b0, 4'd11, SHR, SHR);
    expect_resp("t6_sh", 0);
    send_req(1'b1, 4'd11, MOD, MOD);
    chk("t6_snp_pending", 32'(snp_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_drop", 32'({snp_valid, resp_valid, ack_ready, req_ready}), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    snp_q.delete();
    @(negedge clk);
    chk("t6_idle", 32'({req_ready, snp_valid, resp_valid}), 32'({1'b1, 1'b0, 1'b0}));
    // Directory cleared: previously valid holders are now rejected
    send_req(1'b0, 4'd11, NE, REJ);
    expect_resp("t6_probe11", 0);
    send_req(1'b1, 4'd3, NED, REJ);
    chk("t6_no_wb", 32'(wb_pulse), 32'd0);
    expect_resp("t6_probe3", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
